multicycle_main_control: RTL
============================

// Module: multicycle_main_control
// PURPOSE
//  Main control FSM for the multi-cycle MIPS datapath. Produces the per-state datapath strobes.
//  Drives the 2-bit ALU op code consumed by the ALU control decoder:
//  00 add, 01 sub, 10 use funct, 11 and.
//  Sits between the instruction register opcode field and the datapath.
//  Also counts retired instructions for CPI measurement.
// PARAMETERS
//  CNTW  32  width of instr_count
// PORTS
//  clk            in   1     rising-edge clock
//  rst_n          in   1     asynchronous active-low reset
//  op             in   6     IR[31:26]; valid from the cycle after IR is written
//  mem_ready      in   1     memory completes the current read/write this cycle
//  pc_write       out  1     unconditional PC load
//  pc_write_cond  out  1     PC load if ALU zero
//  iord           out  1     0 = PC addresses memory, 1 = ALUOut addresses memory
//  mem_read       out  1     memory read request
//  mem_write      out  1     memory write request
//  ir_write       out  1     IR load
//  mem_to_reg     out  1     1 = MDR, 0 = ALUOut to register file
//  reg_dst        out  1     1 = rd, 0 = rt
//  reg_write      out  1     register file write
//  alu_src_a      out  1     0 = PC, 1 = A
//  alu_src_b      out  2     00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
//  ext_zero       out  1     1 = zero-extend imm (andi), 0 = sign-extend
//  alu_op         out  2     to ALU control decoder
//  pc_source      out  2     00 ALU, 01 ALUOut, 10 jump target
//  illegal_op     out  1     DECODE saw an unsupported opcode
//  state          out  4     current state (debug)
//  instr_count    out  CNTW  retired instructions
// BEHAVIOUR
//  States, with 4-bit encodings:
//   0 FETCH, 1 DECODE, 2 MEM_ADDR, 3 MEM_READ, 4 MEM_WB, 5 MEM_WRITE, 6 R_EXEC,
//   7 R_WB, 8 BRANCH, 9 JUMP, 10 IMM_EXEC, 11 IMM_WB, 12 IDLE.
//  Reset: rst_n=0 immediately sets state=IDLE, op_q=0, instr_count=0.
//   All outputs are 0 in IDLE. IDLE always goes to FETCH on the next clock.
//  Outputs are Moore-decoded from state. The exceptions are ir_write/pc_write in FETCH, which are qualified by mem_ready.
//  Any output not listed for a state is 0.
//  FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
//   ir_write=pc_write=mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE.
//  DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Latches op into op_q.
//   Next state by op: 100011/101011 -> MEM_ADDR; 000000 -> R_EXEC; 000100 -> BRANCH;
//   000010 -> JUMP; 001000/001100 -> IMM_EXEC.
//   Any other op: illegal_op=1 for this cycle only, next state FETCH, no count.
//  MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_READ if op_q=100011, else MEM_WRITE.
//  MEM_READ: mem_read=1, iord=1. Waits for mem_ready, then goes to MEM_WB.
//  MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
//  MEM_WRITE: mem_write=1, iord=1. Waits for mem_ready, then goes to FETCH.
//  R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB.
//  R_WB: reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
//  JUMP: pc_write=1, pc_source=10 -> FETCH.
//  IMM_EXEC: alu_src_a=1, alu_src_b=10 -> IMM_WB.
//   alu_op=11 and ext_zero=1 if op_q=001100; otherwise alu_op=00 and ext_zero=0.
//  IMM_WB: reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH.
//  Instruction count: instr_count increments by 1 on each transition into FETCH from
//   MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP or IMM_WB. It wraps modulo 2^CNTW.
//  Latency in cycles, with mem_ready=1 on first request:
//   lw 5; sw 4; R-type 4; addi/andi 4; beq 3; j 3.
//   Each cycle mem_ready=0 adds one cycle.
//  mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.
//  op is sampled only in DECODE; later op changes do not alter the instruction in flight.
//  Asserting rst_n mid-instruction aborts it: no further strobes, no count, IDLE next.
// TESTING
//  1. Reset, then add (op=000000), mem_ready=1 -> states 12,0,1,6,7,0.
//     alu_op=10 in R_EXEC; reg_write=reg_dst=1 in R_WB; instr_count=1.
//  2. lw with mem_ready low 2 cycles in MEM_READ -> MEM_READ held 3 cycles;
//     mem_to_reg=1 in MEM_WB; total 7 cycles FETCH to FETCH.
//  3. beq -> alu_op=01, pc_write_cond=1, pc_source=01 for exactly one cycle.
//     j -> pc_write=1, pc_source=10.
//  4. andi (001100) -> alu_op=11, ext_zero=1 in IMM_EXEC. addi -> alu_op=00, ext_zero=0.
//  5. op=111111 -> illegal_op pulses 1 cycle in DECODE, next state FETCH, instr_count unchanged.
//  6. rst_n low during MEM_WRITE -> mem_write drops asynchronously,
//     state=12, instr_count=0; FETCH resumes 1 cycle after release.

Source files
------------

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle MIPS datapath: Moore-decoded datapath strobes,
// ALU op code for the ALU control decoder, and a retired-instruction counter.
module multicycle_main_control #(
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [5:0]      op,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            pc_write_cond,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            mem_to_reg,
    output logic            reg_dst,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic            ext_zero,
    output logic [1:0]      alu_op,
    output logic [1:0]      pc_source,
    output logic            illegal_op,
    output logic [3:0]      state,
    output logic [CNTW-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_IMM_EXEC  = 4'd10,
        S_IMM_WB    = 4'd11,
        S_IDLE      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t          r_state;
    state_t          w_next;
    logic [5:0]      r_op_q;
    logic [CNTW-1:0] r_instr_count;
    logic            w_retire;

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_IDLE:      w_next = S_FETCH;
            S_FETCH:     w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:     w_next = S_MEM_ADDR;
                    OP_RTYPE:         w_next = S_R_EXEC;
                    OP_BEQ:           w_next = S_BRANCH;
                    OP_J:             w_next = S_JUMP;
                    OP_ADDI, OP_ANDI: w_next = S_IMM_EXEC;
                    default:          w_next = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  w_next = (r_op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  w_next = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    w_next = S_FETCH;
            S_MEM_WRITE: w_next = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    w_next = S_R_WB;
            S_R_WB:      w_next = S_FETCH;
            S_BRANCH:    w_next = S_FETCH;
            S_JUMP:      w_next = S_FETCH;
            S_IMM_EXEC:  w_next = S_IMM_WB;
            S_IMM_WB:    w_next = S_FETCH;
            default:     w_next = S_FETCH;
        endcase
    end

    // An instruction retires only when a final state hands back to FETCH; illegal ops never count.
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_MEM_WB, S_MEM_WRITE, S_R_WB, S_BRANCH, S_JUMP, S_IMM_WB:
                w_retire = (w_next == S_FETCH);
            default: w_retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_op_q        <= 6'd0;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_op_q <= op;
            if (w_retire)
                r_instr_count <= r_instr_count + CNTW'(1);
        end
    end

    // Strobes are decoded from the state register so reset clears them without waiting for a clock.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        ext_zero      = 1'b0;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI, OP_ANDI: illegal_op = 1'b0;
                    default: illegal_op = 1'b1;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_IMM_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (r_op_q == OP_ANDI) begin
                    alu_op   = 2'b11;
                    ext_zero = 1'b1;
                end
            end
            S_IMM_WB: begin
                reg_write = 1'b1;
            end
            default: begin
                pc_write = 1'b0;
            end
        endcase
    end

    assign state       = r_state;
    assign instr_count = r_instr_count;

endmodule
